// File: rtl/ddr_rd_sched.sv
// DDR read scheduler: arbitrates weight / feature-map jobs into chunked read-master
// commands and steers the returning AXIS beats into the selected conv-unit buffer.
module ddr_rd_sched #(
  parameter int N_CU         = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 32,
  parameter int BURST_BEATS  = 16,
  parameter int CHUNK_BURSTS = 32,
  parameter int NB_WIDTH     = 18,
  localparam int CU_W        = (N_CU > 1) ? $clog2(N_CU) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [ADDR_WIDTH-1:0] wd_addr,
  input  logic [NB_WIDTH-1:0]   wd_nbursts,
  input  logic [CU_W-1:0]       wd_cu,
  input  logic                  fd_valid,
  output logic                  fd_ready,
  input  logic [ADDR_WIDTH-1:0] fd_addr,
  input  logic [NB_WIDTH-1:0]   fd_nbursts,
  input  logic [CU_W-1:0]       fd_cu,
  output logic                  rd_start,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [NB_WIDTH-1:0]   rd_nbursts,
  input  logic                  rd_done,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  s_axis_tready,
  output logic [N_CU-1:0]       wb_we,
  output logic [N_CU-1:0]       fb_we,
  output logic [DATA_WIDTH-1:0] mem_di,
  input  logic [N_CU-1:0]       wb_full,
  input  logic [N_CU-1:0]       fb_full,
  input  logic                  wb_suff,
  output logic                  busy
);
  localparam int BB   = BURST_BEATS * DATA_WIDTH / 8;
  localparam int BC_W = $clog2(CHUNK_BURSTS * BURST_BEATS + 1);

  typedef enum logic [1:0] {IDLE, ARB, ISSUE, WAIT} state_t;

  // Channel index 0 = weights, 1 = feature maps.
  state_t                       state_q, state_d;
  logic [1:0][ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0][NB_WIDTH-1:0]     rem_q, rem_d;
  logic [1:0][CU_W-1:0]         cu_q, cu_d;
  logic [1:0]                   act_q, act_d;
  logic                         rr_q, rr_d;
  logic                         gch_q, gch_d;
  logic [ADDR_WIDTH-1:0]        rd_addr_q, rd_addr_d;
  logic [NB_WIDTH-1:0]          rd_nb_q, rd_nb_d;
  logic [BC_W-1:0]              beat_q, beat_d;
  logic                         done_q, done_d;

  logic [1:0]          full, elig;
  logic                gnt_vld, gnt_ch, acc, cmpl;
  logic [NB_WIDTH-1:0] rem_g, chunk_nb;
  logic [BC_W-1:0]     beat_tgt, beat_nxt;
  logic [N_CU-1:0]     cu_oh;

  always_comb begin
    full[0] = wb_full[cu_q[0]];
    full[1] = fb_full[cu_q[1]];
    elig    = act_q & ~full;
    gnt_vld = |elig;
    if (!wb_suff)    gnt_ch = ~elig[0];
    else if (&elig)  gnt_ch = ~rr_q;
    else             gnt_ch = elig[1];
    rem_g    = rem_q[gnt_ch];
    chunk_nb = (rem_g > NB_WIDTH'(CHUNK_BURSTS)) ? NB_WIDTH'(CHUNK_BURSTS) : rem_g;

    beat_tgt      = BC_W'(rd_nb_q) * BC_W'(BURST_BEATS);
    s_axis_tready = (state_q == WAIT) && !full[gch_q] && (beat_q < beat_tgt);
    acc           = s_axis_tready && s_axis_tvalid;
    beat_nxt      = beat_q + BC_W'(acc);
    // rd_done may lead, trail or coincide with the last beat.
    cmpl          = (state_q == WAIT) && (done_q || rd_done) && (beat_nxt == beat_tgt);

    cu_oh  = N_CU'(1) << cu_q[gch_q];
    wb_we  = (acc && !gch_q) ? cu_oh : '0;
    fb_we  = (acc &&  gch_q) ? cu_oh : '0;
    mem_di = acc ? s_axis_tdata : '0;
  end

  assign wd_ready   = ~act_q[0];
  assign fd_ready   = ~act_q[1];
  assign rd_start   = (state_q == ISSUE);
  assign rd_addr    = rd_addr_q;
  assign rd_nbursts = rd_nb_q;
  assign busy       = (|act_q) || (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    cu_d      = cu_q;
    act_d     = act_q;
    rr_d      = rr_q;
    gch_d     = gch_q;
    rd_addr_d = rd_addr_q;
    rd_nb_d   = rd_nb_q;
    beat_d    = beat_q;
    done_d    = done_q;

    // ready is ~active, so a completing channel cannot accept in the same cycle.
    if (wd_valid && wd_ready) begin
      addr_d[0] = wd_addr;
      rem_d[0]  = wd_nbursts;
      cu_d[0]   = wd_cu;
      act_d[0]  = |wd_nbursts;
    end
    if (fd_valid && fd_ready) begin
      addr_d[1] = fd_addr;
      rem_d[1]  = fd_nbursts;
      cu_d[1]   = fd_cu;
      act_d[1]  = |fd_nbursts;
    end

    case (state_q)
      IDLE: if (|act_q) state_d = ARB;
      ARB: begin
        if (gnt_vld) begin
          state_d   = ISSUE;
          gch_d     = gnt_ch;
          rr_d      = gnt_ch;
          rd_addr_d = addr_q[gnt_ch];
          rd_nb_d   = chunk_nb;
        end else if (!(|act_q)) begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        beat_d  = '0;
        done_d  = 1'b0;
      end
      WAIT: begin
        beat_d = beat_nxt;
        if (rd_done) done_d = 1'b1;
        if (cmpl) begin
          state_d       = ARB;
          beat_d        = '0;
          done_d        = 1'b0;
          addr_d[gch_q] = addr_q[gch_q] + ADDR_WIDTH'(rd_nb_q) * ADDR_WIDTH'(BB);
          rem_d[gch_q]  = rem_q[gch_q] - rd_nb_q;
          act_d[gch_q]  = (rem_q[gch_q] != rd_nb_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      cu_q      <= '0;
      act_q     <= '0;
      rr_q      <= 1'b0;
      gch_q     <= 1'b0;
      rd_addr_q <= '0;
      rd_nb_q   <= '0;
      beat_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      cu_q      <= cu_d;
      act_q     <= act_d;
      rr_q      <= rr_d;
      gch_q     <= gch_d;
      rd_addr_q <= rd_addr_d;
      rd_nb_q   <= rd_nb_d;
      beat_q    <= beat_d;
      done_q    <= done_d;
    end
  end
endmodule
